// File: rtl/instr_fetch_unit.sv
// +--------------------------------------------------------------------------+
// | instr_fetch_unit: program-loadable instruction memory with a one-deep    |
// | fetch output register, BEQ/redirect handling and illegal-target fault.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module instr_fetch_unit #(
  parameter int unsigned DEPTH    = 64,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  input  logic                     run,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic                     out_beq_taken,
  output logic                     done,
  output logic                     fault,
  output logic [15:0]              fetch_count
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [31:0] PC_LIMIT = 32'(DEPTH) << 2;
  localparam logic [31:0] LAST_PC  = PC_LIMIT - 32'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic [15:0] cnt_q, cnt_d;

  logic [31:0] mem_q [DEPTH];

  logic        w_mem_we;
  logic [31:0] w_rd_data;
  logic        w_accept;
  logic        w_beq;
  logic [31:0] w_br_target;

  // Memory has no reset so a loaded program survives rst_n.
  assign w_mem_we  = (state_q == S_IDLE) && load_en;
  assign w_rd_data = mem_q[pc_q[AW+1:2]];

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign w_accept    = out_valid_q && out_ready;
  assign w_beq       = out_valid_q && (out_instr_q[31:26] == 6'b000100) &&
                       (out_instr_q[25:21] == out_instr_q[20:16]);
  assign w_br_target = out_pc_q + 32'd4 +
                       {{14{out_instr_q[15]}}, out_instr_q[15:0], 2'b00};

  function automatic logic bad_target(input logic [31:0] t);
    return (t[1:0] != 2'b00) || (t >= PC_LIMIT);
  endfunction

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    done_d      = 1'b0;
    fault_d     = fault_q;
    cnt_d       = cnt_q;

    if (w_accept && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (run && !load_en) begin
          state_d     = S_FETCH;
          pc_d        = RESET_PC;
          cnt_d       = 16'd0;
          out_valid_d = 1'b0;
        end
      end
      S_FETCH: begin
        // Priority: redirect, taken branch, end of program, normal fetch.
        if (redirect_valid) begin
          out_valid_d = 1'b0;
          if (bad_target(redirect_pc)) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (w_accept && w_beq) begin
          out_valid_d = 1'b0;
          if (bad_target(w_br_target)) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end else begin
            pc_d = w_br_target;
          end
        end else if (w_accept && (out_pc_q == LAST_PC)) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
          done_d      = 1'b1;
        end else if (!out_valid_q || out_ready) begin
          if (pc_q < PC_LIMIT) begin
            out_instr_d = w_rd_data;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + 32'd4;
          end else begin
            out_valid_d = 1'b0;
          end
        end
      end
      S_FAULT: begin
        out_valid_d = 1'b0;
        fault_d     = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0;
      out_pc_q    <= 32'h0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      cnt_q       <= 16'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_instr     = out_instr_q;
  assign out_pc        = out_pc_q;
  assign out_beq_taken = w_beq;
  assign done          = done_q;
  assign fault         = fault_q;
  assign fetch_count   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// +--------------------------------------------------------------------------+
// | tb_instr_fetch_unit: directed bench for instr_fetch_unit (DEPTH 64 and 4)|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_instr_fetch_unit;

  localparam logic [31:0] I_ADD = 32'h012A4020;
  localparam logic [31:0] I_SUB = 32'h012A4022;
  localparam logic [31:0] I_AND = 32'h012A4024;
  localparam logic [31:0] I_OR  = 32'h012A4025;
  localparam logic [31:0] I_BEQ = 32'h12730003;  // beq $s3,$s3,+3
  localparam logic [31:0] I_W4  = 32'h11111111;
  localparam logic [31:0] I_W6  = 32'h66666666;

  logic        clk;
  logic        rst_n;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [31:0] load_data;
  logic        run;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_beq_taken;
  logic        done;
  logic        fault;
  logic [15:0] fetch_count;

  logic        b_load_en;
  logic [1:0]  b_load_addr;
  logic [31:0] b_load_data;
  logic        b_run;
  logic        b_redirect_valid;
  logic [31:0] b_redirect_pc;
  logic        b_out_ready;
  logic        b_out_valid;
  logic [31:0] b_out_instr;
  logic [31:0] b_out_pc;
  logic        b_out_beq_taken;
  logic        b_done;
  logic        b_fault;
  logic [15:0] b_fetch_count;

  int n_total = 0;
  int n_pass  = 0;

  instr_fetch_unit #(.DEPTH(64), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .run(run), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_ready(out_ready), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc), .out_beq_taken(out_beq_taken),
    .done(done), .fault(fault), .fetch_count(fetch_count)
  );

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .load_en(b_load_en), .load_addr(b_load_addr),
    .load_data(b_load_data), .run(b_run), .redirect_valid(b_redirect_valid),
    .redirect_pc(b_redirect_pc), .out_ready(b_out_ready), .out_valid(b_out_valid),
    .out_instr(b_out_instr), .out_pc(b_out_pc), .out_beq_taken(b_out_beq_taken),
    .done(b_done), .fault(b_fault), .fetch_count(b_fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic load_a(input logic [5:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic load_b(input logic [1:0] a, input logic [31:0] d);
    b_load_en = 1'b1; b_load_addr = a; b_load_data = d;
    step();
    b_load_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0; run = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    b_load_en = 1'b0; b_load_addr = '0; b_load_data = '0; b_run = 1'b0;
    b_redirect_valid = 1'b0; b_redirect_pc = '0; b_out_ready = 1'b0;
    repeat (2) step();

    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_beq", 32'(out_beq_taken), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_count", 32'(fetch_count), 32'd0);
    chk("rst_b_valid", 32'(b_out_valid), 32'd0);

    rst_n = 1'b1;
    step();
    load_a(6'd0, I_ADD); load_a(6'd1, I_SUB); load_a(6'd2, I_AND);
    load_a(6'd3, I_OR);  load_a(6'd4, I_W4);  load_a(6'd6, I_W6);

    // Straight-line fetch, one word per cycle.
    out_ready = 1'b1; run = 1'b1;
    step(); run = 1'b0;
    chk("seq_first_bubble", 32'(out_valid), 32'd0);
    step(); chk("seq_pc0", out_pc, 32'd0);  chk("seq_i0", out_instr, I_ADD);
    chk("seq_v0", 32'(out_valid), 32'd1);
    step(); chk("seq_pc4", out_pc, 32'd4);  chk("seq_i1", out_instr, I_SUB);
    step(); chk("seq_pc8", out_pc, 32'd8);  chk("seq_i2", out_instr, I_AND);
    step(); chk("seq_pc12", out_pc, 32'd12); chk("seq_i3", out_instr, I_OR);
    chk("seq_cnt3", 32'(fetch_count), 32'd3);
    step(); chk("seq_pc16", out_pc, 32'd16); chk("seq_cnt4", 32'(fetch_count), 32'd4);

    // Asynchronous reset with a valid output in flight.
    rst_n = 1'b0; #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_pc", out_pc, 32'd0);
    chk("async_instr", out_instr, 32'd0);
    chk("async_count", 32'(fetch_count), 32'd0);
    step(); rst_n = 1'b1; step();
    run = 1'b1; step(); run = 1'b0; step();
    chk("refetch_pc0", out_pc, 32'd0); chk("refetch_i0", out_instr, I_ADD);

    // Back-pressure: hold at out_pc=4 for three cycles.
    step(); chk("bp_pc4", out_pc, 32'd4);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_pc", out_pc, 32'd4);
      chk("bp_hold_instr", out_instr, I_SUB);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    chk("bp_cnt", 32'(fetch_count), 32'd1);
    out_ready = 1'b1;
    step(); chk("bp_resume_pc", out_pc, 32'd8); chk("bp_resume_i", out_instr, I_AND);
    chk("bp_resume_cnt", 32'(fetch_count), 32'd2);

    // Taken BEQ at word 2: target 8+4+12 = 24.
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    load_a(6'd2, I_BEQ);
    run = 1'b1; step(); run = 1'b0;
    step(); step(); step();
    chk("beq_pc8", out_pc, 32'd8);
    chk("beq_taken", 32'(out_beq_taken), 32'd1);
    step(); chk("beq_bubble", 32'(out_valid), 32'd0);
    chk("beq_bubble_taken", 32'(out_beq_taken), 32'd0);
    step(); chk("beq_target_pc", out_pc, 32'd24); chk("beq_target_i", out_instr, I_W6);
    chk("beq_cnt", 32'(fetch_count), 32'd3);

    // Legal redirect to 0x10.
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step(); redirect_valid = 1'b0;
    chk("redir_bubble", 32'(out_valid), 32'd0);
    step(); chk("redir_pc", out_pc, 32'h10); chk("redir_i", out_instr, I_W4);

    // Misaligned redirect faults; fault is sticky until reset.
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    step(); redirect_valid = 1'b0;
    chk("fault_set", 32'(fault), 32'd1);
    chk("fault_valid", 32'(out_valid), 32'd0);
    run = 1'b1; step(); run = 1'b0;
    chk("fault_sticky", 32'(fault), 32'd1);
    chk("fault_no_fetch", 32'(out_valid), 32'd0);
    rst_n = 1'b0; #1;
    chk("fault_clear", 32'(fault), 32'd0);
    step(); rst_n = 1'b1; run = 1'b1;
    step(); run = 1'b0;
    chk("idle_restart_bubble", 32'(out_valid), 32'd0);
    step(); chk("idle_restart_valid", 32'(out_valid), 32'd1);
    chk("idle_restart_pc", out_pc, 32'd0);

    // DEPTH=4 instance: end-of-program done pulse, no wrap-around.
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    load_b(2'd0, I_ADD); load_b(2'd1, I_SUB); load_b(2'd2, I_AND); load_b(2'd3, I_OR);
    b_out_ready = 1'b1; b_run = 1'b1;
    step(); b_run = 1'b0;
    step(); chk("d4_pc0", b_out_pc, 32'd0);
    step(); chk("d4_pc4", b_out_pc, 32'd4);
    step(); chk("d4_pc8", b_out_pc, 32'd8);
    step(); chk("d4_pc12", b_out_pc, 32'd12); chk("d4_i3", b_out_instr, I_OR);
    chk("d4_done_early", 32'(b_done), 32'd0);
    step(); chk("d4_done", 32'(b_done), 32'd1);
    chk("d4_end_valid", 32'(b_out_valid), 32'd0);
    chk("d4_cnt", 32'(b_fetch_count), 32'd4);
    step(); chk("d4_done_once", 32'(b_done), 32'd0);
    chk("d4_no_wrap", 32'(b_out_valid), 32'd0);
    b_run = 1'b1; step(); b_run = 1'b0;
    step(); chk("d4_idle_rerun_pc", b_out_pc, 32'd0);
    chk("d4_idle_rerun_valid", 32'(b_out_valid), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
